// File: rtl/booth_mul_sched.sv
`default_nettype none
// ============================================================================
// Module      : booth_mul_sched
// Description : Shared iterative radix-2 Booth multiplier with a round-robin
//               scheduler in front. Computes one Booth step per clock and
//               returns the signed 2*WIDTH-bit product tagged with the
//               index of the requester that owns it.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mul_sched #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [2*WIDTH-1:0]       resp_result,
    output logic                     busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ACC_W = 2*WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               resp_valid_q, resp_valid_d;

    logic               gnt_found;
    logic               hi_found;
    logic [ID_W-1:0]    hi_idx;
    logic [ID_W-1:0]    lo_idx;
    logic [ID_W-1:0]    gnt_idx;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic [WIDTH-1:0]   gnt_a;
    logic [WIDTH-1:0]   gnt_b;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH:0]     step_sum;

    // Round-robin pick: lowest valid index at or above rr_ptr, otherwise
    // wrap around to the lowest valid index overall.
    always_comb begin
        gnt_found = 1'b0;
        hi_found  = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        for (int i = NUM_REQ-1; i >= 0; i--) begin
            if (req_valid[i]) begin
                gnt_found = 1'b1;
                lo_idx    = ID_W'(i);
                if (ID_W'(i) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end
            end
        end
        gnt_idx = hi_found ? hi_idx : lo_idx;
    end

    // Decode the winner into a one-hot grant and select its operands.
    always_comb begin
        gnt_onehot = '0;
        gnt_a      = '0;
        gnt_b      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                gnt_onehot[i] = gnt_found;
                gnt_a         = req_a[i*WIDTH +: WIDTH];
                gnt_b         = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign acc_hi = acc_q[ACC_W-1 -: WIDTH];

    // Booth add/subtract on the upper partial product. The sum is formed one
    // bit wider so the bit shifted in is the true sign even when a is the
    // most-negative value; the stored upper half stays WIDTH bits.
    always_comb begin
        case (acc_q[1:0])
            2'b01:   step_sum = {acc_hi[WIDTH-1], acc_hi} + {a_q[WIDTH-1], a_q};
            2'b10:   step_sum = {acc_hi[WIDTH-1], acc_hi} - {a_q[WIDTH-1], a_q};
            default: step_sum = {acc_hi[WIDTH-1], acc_hi};
        endcase
    end

    // Scheduler / datapath next-state logic.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        acc_d        = acc_q;
        a_d          = a_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    acc_d    = {{WIDTH{1'b0}}, gnt_b, 1'b0};
                    a_d      = gnt_a;
                    id_d     = gnt_idx;
                    rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
                    cnt_d    = '0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                // Arithmetic shift right by one after the add/subtract.
                acc_d = {step_sum, acc_q[WIDTH:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d      = S_DONE;
                    resp_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            acc_q        <= '0;
            a_q          <= '0;
            id_q         <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            acc_q        <= acc_d;
            a_q          <= a_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // Grants only in IDLE; gated by reset so outputs read zero immediately.
    assign req_ready   = (state_q == S_IDLE && rst_n) ? gnt_onehot : '0;
    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_valid_q ? acc_q[ACC_W-1:1] : '0;
    assign resp_id     = resp_valid_q ? id_q : '0;
    assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_mul_sched
// Description : Scoreboard bench for booth_mul_sched. Accepted requests push
//               the reference signed product; a monitor pops and compares on
//               each response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mul_sched;

    localparam int W   = 32;
    localparam int N   = 2;
    localparam int IDW = 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           resp_valid;
    logic           resp_ready;
    logic [IDW-1:0] resp_id;
    logic [2*W-1:0] resp_result;
    logic           busy;

    always #5 clk = ~clk;

    booth_mul_sched #(.WIDTH(W), .NUM_REQ(N), .ID_W(IDW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .busy        (busy)
    );

    typedef struct {
        int          id;
        logic [63:0] prod;
        int          edge_no;
    } exp_t;

    exp_t        sb[$];
    int          grant_log[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cnt[N];
    int          seen_cnt[N];
    logic [63:0] last_res[N];
    logic        prev_valid = 1'b0;
    logic        prev_hs = 1'b0;
    logic [63:0] prev_result = '0;
    logic [IDW-1:0] prev_id = '0;

    task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: plain signed multiply at 64 bits.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint x, y;
        x = longint'($signed(a));
        y = longint'($signed(b));
        return 64'(x * y);
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(7))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: record accepts into the scoreboard, check responses.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            check($countones(req_ready) <= 1, "ready_onehot", 64'(req_ready), 64'd1);
            if (busy) check(req_ready == '0, "ready_while_busy", 64'(req_ready), 64'd0);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id      = i;
                    e.prod    = ref_mul(req_a[i*W +: W], req_b[i*W +: W]);
                    e.edge_no = cyc + 1;
                    sb.push_back(e);
                    grant_log.push_back(i);
                    acc_cnt[i]++;
                end
            end
            if (resp_valid) begin
                if (!prev_valid || prev_hs) begin
                    if (sb.size() == 0)
                        check(1'b0, "unexpected_resp", resp_result, 64'd0);
                    else
                        check(cyc - sb[0].edge_no == W, "latency", 64'(cyc - sb[0].edge_no), 64'(W));
                end else begin
                    check(resp_result == prev_result && resp_id == prev_id, "hold_stable",
                          resp_result, prev_result);
                end
                if (resp_ready && sb.size() > 0) begin
                    e = sb.pop_front();
                    check(int'(resp_id) == e.id, "resp_id", 64'(resp_id), 64'(e.id));
                    check(resp_result == e.prod, "resp_result", resp_result, e.prod);
                    last_res[e.id] = resp_result;
                end
            end
            prev_valid  = resp_valid;
            prev_hs     = resp_valid && resp_ready;
            prev_result = resp_result;
            prev_id     = resp_id;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic drop_accepted();
        for (int i = 0; i < N; i++) begin
            if (acc_cnt[i] != seen_cnt[i]) begin
                seen_cnt[i]  = acc_cnt[i];
                req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        while ((sb.size() != 0 || busy || resp_valid || req_valid != '0) && t < 500) begin
            tick();
            drop_accepted();
            t++;
        end
        check(t < 500, {nm, "_drain"}, 64'(t), 64'd500);
    endtask

    task automatic single(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string nm);
        set_op(i, a, b);
        req_valid[i] = 1'b1;
        resp_ready   = 1'b1;
        wait_idle(nm);
        check(last_res[i] == exp, nm, last_res[i], exp);
    endtask

    task automatic traffic(input int n0, input int n1, input bit rnd_ready, input bit rnd_drop,
                           input string nm);
        int rem[N];
        int t;
        rem[0] = n0;
        rem[1] = n1;
        t      = 0;
        while ((rem[0] > 0 || rem[1] > 0 || req_valid != '0) && t < 60000) begin
            drop_accepted();
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && rem[i] > 0 && (!rnd_drop || $urandom_range(3) != 0)) begin
                    set_op(i, rnd_op(), rnd_op());
                    req_valid[i] = 1'b1;
                    rem[i]--;
                end else if (req_valid[i] && rnd_drop && $urandom_range(31) == 0) begin
                    req_valid[i] = 1'b0;
                    rem[i]++;
                end
            end
            resp_ready = rnd_ready ? ($urandom_range(3) != 0) : 1'b1;
            tick();
            t++;
        end
        check(t < 60000, {nm, "_timeout"}, 64'(t), 64'd60000);
        resp_ready = 1'b1;
        wait_idle(nm);
    endtask

    initial begin : drv
        int t;
        int base;
        logic [63:0]    hold;
        logic [IDW-1:0] hid;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < N; i++) seen_cnt[i] = 0;
        repeat (3) @(negedge clk);
        check(resp_valid == 1'b0 && busy == 1'b0 && req_ready == '0, "reset_ctrl",
              64'({resp_valid, busy, req_ready}), 64'd0);
        check(resp_result == '0, "reset_result", resp_result, 64'd0);
        check(resp_id == '0, "reset_id", 64'(resp_id), 64'd0);
        rst_n = 1'b1;
        tick();

        // Contention straight from reset: expect r0, r1, r0, r1.
        base = grant_log.size();
        traffic(2, 2, 1'b0, 1'b0, "contention");
        check(grant_log.size() == base + 4, "grant_count", 64'(grant_log.size() - base), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (grant_log.size() > base + k)
                check(grant_log[base+k] == k % 2, "grant_order", 64'(grant_log[base+k]), 64'(k % 2));
        end

        // Single request 3*5 with grant, response and busy timing.
        set_op(0, 32'd3, 32'd5);
        req_valid[0] = 1'b1;
        resp_ready   = 1'b1;
        #1;
        check(req_ready == 2'b01, "idle_grant_r0", 64'(req_ready), 64'd1);
        t = 0;
        while (!resp_valid && t < 100) begin
            tick();
            drop_accepted();
            t++;
        end
        check(t < 100, "single_wait", 64'(t), 64'd100);
        check(resp_result == 64'd15, "single_result", resp_result, 64'd15);
        check(resp_id == 1'b0, "single_id", 64'(resp_id), 64'd0);
        tick();
        check(busy == 1'b0 && resp_valid == 1'b0, "busy_after_hs", 64'({busy, resp_valid}), 64'd0);
        wait_idle("single");

        // Signed corner cases.
        single(0, 32'hFFFF_FFF9, 32'd6,        64'hFFFF_FFFF_FFFF_FFD6, "neg7x6");
        single(1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "minxmin");
        single(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1,                   "m1xm1");
        single(1, 32'd0,         32'h7FFF_FFFF, 64'd0,                   "zeroxmax");

        // Backpressure: result held, no grants while DONE.
        resp_ready = 1'b0;
        set_op(0, 32'hFFFF_FFFD, 32'd11);
        set_op(1, 32'd100, 32'hFFFF_FF9C);
        req_valid = 2'b01;
        t = 0;
        while (req_valid[0] && t < 50) begin
            tick();
            drop_accepted();
            t++;
        end
        req_valid[1] = 1'b1;
        t = 0;
        while (!resp_valid && t < 100) begin
            tick();
            t++;
        end
        check(t < 100, "bp_wait", 64'(t), 64'd100);
        hold = resp_result;
        hid  = resp_id;
        repeat (10) begin
            @(negedge clk);
            check(req_ready == '0, "bp_ready_zero", 64'(req_ready), 64'd0);
            check(resp_valid && resp_result == hold && resp_id == hid, "bp_hold", resp_result, hold);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check(resp_valid == 1'b0, "bp_consumed", 64'(resp_valid), 64'd0);
        check(last_res[0] == 64'hFFFF_FFFF_FFFF_FFDF, "bp_result", last_res[0], 64'hFFFF_FFFF_FFFF_FFDF);
        wait_idle("bp_drain");

        // Reset in the middle of CALC.
        set_op(1, 32'h1234_5678, 32'h9ABC_DEF0);
        req_valid = 2'b10;
        t = 0;
        while (req_valid != '0 && t < 50) begin
            tick();
            drop_accepted();
            t++;
        end
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check(resp_valid == 1'b0 && busy == 1'b0 && req_ready == '0, "midrst_ctrl",
              64'({resp_valid, busy, req_ready}), 64'd0);
        check(resp_result == '0 && resp_id == '0, "midrst_data", resp_result, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        set_op(0, 32'd2, 32'd2);
        set_op(1, 32'd7, 32'd9);
        req_valid = 2'b11;
        #1;
        check(req_ready == 2'b01, "rr_after_reset", 64'(req_ready), 64'd1);
        wait_idle("post_reset");
        check(last_res[0] == 64'd4, "post_reset_r0", last_res[0], 64'd4);
        check(last_res[1] == 64'd63, "post_reset_r1", last_res[1], 64'd63);

        // Random regression with random backpressure and request drops.
        traffic(500, 500, 1'b1, 1'b1, "random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
